// File: rtl/std_fp_div_pkg.sv
// Shared types and width-generic helpers for the sequential fixed-point divider.
// Helpers work on a 64-bit carrier; callers cast the result down to their width.
package std_fp_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;

  localparam int FP_MAX_W = 64;

  function automatic logic [FP_MAX_W-1:0] fp_mask(input int w);
    return {FP_MAX_W{1'b1}} >> (FP_MAX_W - w);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_neg(input logic [FP_MAX_W-1:0] x, input int w);
    return (~x + FP_MAX_W'(1)) & fp_mask(w);
  endfunction

  // Magnitude of a w-bit two's-complement value; the most negative value maps to 2^(w-1).
  function automatic logic [FP_MAX_W-1:0] fp_abs(input logic [FP_MAX_W-1:0] x, input int w);
    return x[w-1] ? fp_neg(x, w) : (x & fp_mask(w));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_sat_max(input int w);
    return fp_mask(w) >> 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_sat_min(input int w);
    return FP_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/std_fp_div_step.sv
// One combinational restoring shift-subtract step of the magnitude divider.
module std_fp_div_step #(
  parameter int WIDTH = 32,
  parameter int N     = 48
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [N-1:0]     q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   acc_o,
  output logic [N-1:0]     q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  assign shifted = {acc_i, q_i[N-1]};
  assign ge      = (shifted >= {2'b00, divisor_i});
  // The shifted partial remainder stays below 2*divisor, so the low bits carry the full difference.
  assign diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
  assign acc_o   = ge ? diff : shifted[WIDTH:0];
  assign q_o     = {q_i[N-2:0], ge};

endmodule

// File: rtl/std_fp_div_seq.sv
// Iterative fixed-point divider: Q = (left << FRAC_WIDTH) / right, R = (left << FRAC_WIDTH) % right.
// Build option STD_FP_DIV_SAT_EN: saturate the quotient on overflow instead of wrapping.
module std_fp_div_seq
  import std_fp_div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int SIGNED     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N     = WIDTH + FRAC_WIDTH;
  localparam int IDX_W = $clog2(N + 1);
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] S_MAX = WIDTH'(fp_sat_max(WIDTH));
  localparam logic [WIDTH-1:0] S_MIN = WIDTH'(fp_sat_min(WIDTH));

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_width_check
    $error("std_fp_div_seq: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  div_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             qneg_q, qneg_d;
  logic             lneg_q, lneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
  logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   acc_step;
  logic [N-1:0]     quo_step;

  std_fp_div_step #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_step (
    .acc_i     (acc_q),
    .q_i       (quo_q),
    .divisor_i (div_q),
    .acc_o     (acc_step),
    .q_o       (quo_step)
  );

  logic [WIDTH-1:0]      l_abs, r_abs, q_lo, q_wrap, q_fix, r_mag, r_fix, l_mag, dz_quot, dz_rem;
  logic [FRAC_WIDTH-1:0] q_hi;
  logic                  ov;

  always_comb begin
    l_abs = IS_SIGNED ? WIDTH'(fp_abs(FP_MAX_W'(left), WIDTH)) : left;
    r_abs = IS_SIGNED ? WIDTH'(fp_abs(FP_MAX_W'(right), WIDTH)) : right;

    q_lo = quo_q[WIDTH-1:0];
    q_hi = quo_q[N-1:WIDTH];
    // A negative result may reach exactly 2^(WIDTH-1) in magnitude; a positive one may not.
    if (!IS_SIGNED) begin
      ov = |q_hi;
    end else if (qneg_q) begin
      ov = (|q_hi) | (q_lo[WIDTH-1] & (|q_lo[WIDTH-2:0]));
    end else begin
      ov = (|q_hi) | q_lo[WIDTH-1];
    end
    q_wrap = qneg_q ? WIDTH'(fp_neg(FP_MAX_W'(q_lo), WIDTH)) : q_lo;
`ifdef STD_FP_DIV_SAT_EN
    if (ov) begin
      q_fix = !IS_SIGNED ? ALL_ONES : (qneg_q ? S_MIN : S_MAX);
    end else begin
      q_fix = q_wrap;
    end
`else
    q_fix = q_wrap;
`endif
    r_mag = acc_q[WIDTH-1:0];
    r_fix = lneg_q ? WIDTH'(fp_neg(FP_MAX_W'(r_mag), WIDTH)) : r_mag;

    // On divide-by-zero the dividend magnitude is still parked in the quotient register.
    l_mag   = quo_q[N-1:FRAC_WIDTH];
    dz_quot = !IS_SIGNED ? ALL_ONES : (lneg_q ? S_MIN : S_MAX);
    dz_rem  = lneg_q ? WIDTH'(fp_neg(FP_MAX_W'(l_mag), WIDTH)) : l_mag;
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    acc_d           = acc_q;
    quo_d           = quo_q;
    div_d           = div_q;
    qneg_d          = qneg_q;
    lneg_d          = lneg_q;
    dz_d            = dz_q;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    done_d          = 1'b0;
    div_by_zero_d   = div_by_zero_q;
    overflow_d      = overflow_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          acc_d  = '0;
          quo_d  = {l_abs, {FRAC_WIDTH{1'b0}}};
          div_d  = r_abs;
          qneg_d = IS_SIGNED & (left[WIDTH-1] ^ right[WIDTH-1]);
          lneg_d = IS_SIGNED & left[WIDTH-1];
          idx_d  = '0;
          if (right == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!go) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          quo_d = quo_step;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (!go) begin
          state_d = IDLE;
        end else begin
          out_quotient_d  = q_fix;
          out_remainder_d = r_fix;
          div_by_zero_d   = 1'b0;
          overflow_d      = ov;
          done_d          = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: begin
        // First DONE cycle of a divide-by-zero loads results; go is ignored here either way.
        if (dz_q) begin
          out_quotient_d  = dz_quot;
          out_remainder_d = dz_rem;
          div_by_zero_d   = 1'b1;
          overflow_d      = 1'b0;
          done_d          = 1'b1;
          dz_d            = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      acc_q           <= '0;
      quo_q           <= '0;
      div_q           <= '0;
      qneg_q          <= 1'b0;
      lneg_q          <= 1'b0;
      dz_q            <= 1'b0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      done_q          <= 1'b0;
      div_by_zero_q   <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      acc_q           <= acc_d;
      quo_q           <= quo_d;
      div_q           <= div_d;
      qneg_q          <= qneg_d;
      lneg_q          <= lneg_d;
      dz_q            <= dz_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      done_q          <= done_d;
      div_by_zero_q   <= div_by_zero_d;
      overflow_q      <= overflow_d;
    end
  end

  assign out_quotient  = out_quotient_q;
  assign out_remainder = out_remainder_q;
  assign done          = done_q;
  assign div_by_zero   = div_by_zero_q;
  assign overflow      = overflow_q;

endmodule
